// File: rtl/led_pwm_fader.sv
// Per-channel afterglow fader with global brightness cap driving one shared PWM.
// Latency: pattern_in -> pattern_q 1 cycle, level changes on fade ticks, duty takes effect at the next PWM period.
// No backpressure: a free-running stream consumer; enable=0 freezes all state and blanks the outputs.
module led_pwm_fader #(
    parameter int N_LED     = 8,
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 1024,
    parameter int STEP_UP   = 255,
    parameter int STEP_DOWN = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_LED-1:0]    pattern_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LED-1:0]    pwm_out,
    output logic                period_start,
    output logic                active
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW   = 2 * PWM_BITS + 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PWM_BITS:0]   LVL_MAX  = (PWM_BITS + 1)'((1 << PWM_BITS) - 1);
    localparam logic [PWM_BITS:0]   UP       = (PWM_BITS + 1)'(STEP_UP);
    localparam logic [PWM_BITS:0]   DOWN     = (PWM_BITS + 1)'(STEP_DOWN);

    logic [N_LED-1:0]    pattern_q;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level    [N_LED];
    logic [PWM_BITS-1:0] duty_q   [N_LED];
    logic [PWM_BITS-1:0] duty_new [N_LED];
    logic [PWM_BITS-1:0] duty_eff [N_LED];
    logic                tick;
    logic                any_lit;

    function automatic logic [PWM_BITS-1:0] fade(input logic [PWM_BITS-1:0] lvl, input logic lit);
        logic [PWM_BITS:0] wide;
        wide = {1'b0, lvl};
        if (lit) begin
            wide = wide + UP;
            if (wide > LVL_MAX)
                wide = LVL_MAX;
        end else begin
            wide = (wide >= DOWN) ? wide - DOWN : '0;
        end
        return wide[PWM_BITS-1:0];
    endfunction

    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] lvl,
                                                  input logic [PWM_BITS-1:0] cap);
        logic [PW-1:0] prod;
        prod = PW'(lvl) * (PW'(cap) + PW'(1));
        return PWM_BITS'(prod >> PWM_BITS);
    endfunction

    assign tick = enable && (prescaler == PS_LAST);

    // At the period boundary the freshly computed duty drives the compare directly,
    // so the first cycle of a period already uses that period's duty.
    always_comb begin
        any_lit = 1'b0;
        for (int i = 0; i < N_LED; i++) begin
            duty_new[i] = scale(level[i], brightness);
            duty_eff[i] = (pwm_cnt == '0) ? duty_new[i] : duty_q[i];
            if (level[i] != '0)
                any_lit = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q    <= '0;
            prescaler    <= '0;
            pwm_cnt      <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            active       <= 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                level[i]  <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            active <= any_lit;
            if (enable) begin
                pattern_q    <= pattern_in;
                prescaler    <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
                pwm_cnt      <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
                period_start <= (pwm_cnt == '0);
                for (int i = 0; i < N_LED; i++) begin
                    if (tick)
                        level[i] <= fade(level[i], pattern_q[i]);
                    if (pwm_cnt == '0)
                        duty_q[i] <= duty_new[i];
                    pwm_out[i] <= (duty_eff[i] > pwm_cnt);
                end
            end else begin
                pwm_out      <= '0;
                period_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomised bench for led_pwm_fader against an arithmetic reference model.
module tb_led_pwm_fader;

    localparam int N      = 8;
    localparam int PB     = 4;
    localparam int TD     = 4;
    localparam int SU     = 15;
    localparam int SD     = 5;
    localparam int PERIOD = (1 << PB) - 1;
    localparam int LMAX   = (1 << PB) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  pattern_in;
    logic [PB-1:0] brightness;
    logic [N-1:0]  pwm_out;
    logic          period_start;
    logic          active;

    led_pwm_fader #(
        .N_LED(N), .PWM_BITS(PB), .TICK_DIV(TD), .STEP_UP(SU), .STEP_DOWN(SD)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .pattern_in(pattern_in),
        .brightness(brightness), .pwm_out(pwm_out), .period_start(period_start),
        .active(active)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: timing derived from the count of enabled cycles since reset.
    int           en_count;
    int           m_level [N];
    int           m_duty  [N];
    logic [N-1:0] m_pattern;
    logic [N-1:0] exp_pwm;
    logic         exp_ps;
    logic         exp_active;

    task automatic model_reset();
        en_count   = 0;
        m_pattern  = '0;
        exp_pwm    = '0;
        exp_ps     = 1'b0;
        exp_active = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_level[i] = 0;
            m_duty[i]  = 0;
        end
    endtask

    task automatic model_step();
        int cnt;
        int phase;
        if (reset) begin
            model_reset();
            return;
        end
        exp_active = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_level[i] != 0) exp_active = 1'b1;
        if (!enable) begin
            exp_pwm = '0;
            exp_ps  = 1'b0;
            return;
        end
        cnt   = en_count % PERIOD;
        phase = en_count % TD;
        exp_ps = (cnt == 0);
        for (int i = 0; i < N; i++) begin
            if (cnt == 0)
                m_duty[i] = (m_level[i] * (int'(brightness) + 1)) >> PB;
            exp_pwm[i] = (m_duty[i] > cnt);
        end
        if (phase == TD - 1)
            for (int i = 0; i < N; i++)
                m_level[i] = m_pattern[i] ? ((m_level[i] + SU > LMAX) ? LMAX : m_level[i] + SU)
                                          : ((m_level[i] - SD < 0) ? 0 : m_level[i] - SD);
        m_pattern = pattern_in;
        en_count++;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check("period_start", 32'(period_start), 32'(exp_ps));
        check("active", 32'(active), 32'(exp_active));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_async_reset();
        reset = 1'b1;
        #1;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        model_reset();
        run(2);
        reset = 1'b0;
    endtask

    task automatic wait_period_start(input string tag);
        int n = 0;
        while (period_start !== 1'b1 && n < 2 * PERIOD) begin
            cycle();
            n++;
        end
        if (period_start !== 1'b1)
            check({tag, "_timeout"}, 32'(period_start), 32'd1);
    endtask

    task automatic measure_high(input int exp, input string tag);
        int hi;
        cycle();
        wait_period_start(tag);
        hi = int'(pwm_out[0]);
        for (int k = 1; k < PERIOD; k++) begin
            cycle();
            hi += int'(pwm_out[0]);
        end
        check(tag, 32'(hi), 32'(exp));
    endtask

    initial begin
        int pulses;
        int last;
        int hi;
        int n;

        reset      = 1'b1;
        enable     = 1'b0;
        pattern_in = '0;
        brightness = '0;
        model_reset();
        #2;
        check("init_pwm_out", 32'(pwm_out), 32'd0);
        check("init_period_start", 32'(period_start), 32'd0);
        check("init_active", 32'(active), 32'd0);
        run(3);
        reset  = 1'b0;
        enable = 1'b1;

        // Reset mid-run, then idle.
        pattern_in = 8'hA5;
        brightness = 4'hF;
        run(23);
        do_async_reset();
        pattern_in = '0;
        brightness = 4'(($urandom_range(0, 15)));
        pulses = 0;
        last   = -1;
        for (int k = 0; k < 200; k++) begin
            cycle();
            if (period_start === 1'b1) begin
                if (last >= 0) check("ps_spacing", 32'(k - last), 32'(PERIOD));
                last = k;
                pulses++;
            end
        end
        check("idle_pulses", 32'(pulses), 32'd14);

        // Full-on channel 0.
        pattern_in = 8'h01;
        brightness = 4'hF;
        run(10);
        measure_high(15, "full_on");

        // Decay to dark.
        pattern_in = 8'h00;
        run(20);
        measure_high(0, "decay_dark");

        // Brightness scaling.
        pattern_in = 8'hFF;
        brightness = 4'd7;
        run(10);
        measure_high(7, "bright7");
        brightness = 4'd0;
        run(16);
        measure_high(0, "bright0");

        // Brightness change mid-period only affects the next period.
        brightness = 4'hF;
        run(16);
        wait_period_start("glitch");
        hi = int'(pwm_out[0]);
        for (int k = 1; k < PERIOD; k++) begin
            if (k == 5) brightness = 4'h3;
            cycle();
            hi += int'(pwm_out[0]);
        end
        check("glitch_cur", 32'(hi), 32'd15);
        measure_high(3, "glitch_next");

        // Freeze mid-decay at level 10.
        brightness = 4'hF;
        pattern_in = 8'h01;
        run(10);
        pattern_in = 8'h00;
        n = 0;
        while (m_level[0] != 10 && n < 20) begin
            cycle();
            n++;
        end
        check("freeze_reach10", 32'(m_level[0]), 32'd10);
        enable = 1'b0;
        hi = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            hi += (pwm_out != '0) ? 1 : 0;
        end
        check("freeze_blank", 32'(hi), 32'd0);
        check("freeze_active", 32'(active), 32'd1);
        enable = 1'b1;
        run(30);

        // Random traffic.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 7) == 0) pattern_in = 8'($urandom());
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom());
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) do_async_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
